// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control-bit layout and
// the control portion of the stage payload.
package ex_mem_stage_pkg;

    localparam int CTL_W       = 5;
    localparam int CTL_BRANCH  = 4;
    localparam int CTL_MEMRD   = 3;
    localparam int CTL_MEMWR   = 2;
    localparam int CTL_REGWR   = 1;
    localparam int CTL_MEM2REG = 0;

    // Data-width-independent part of an entry; wide fields are appended by the stage.
    typedef struct packed {
        logic [CTL_W-1:0] ctl;
        logic             zero;
    } stage_hdr_t;

endpackage

// File: rtl/ex_mem_stage_entry.sv
// One pipeline slot: a valid bit plus a load-enabled payload register, both
// cleared asynchronously.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_d,
    input  logic         load,
    input  logic [W-1:0] data_d,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= valid_d;
            if (load) begin
                data <= data_d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a 2-entry skid buffer (head + skid) so the
// upstream ready is a flop and never sees out_ready combinationally.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTL_W-1:0]   in_ctl,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_store,
    input  logic [DATA_W-1:0]  in_target,
    input  logic               in_zero,
    input  logic [RADDR_W-1:0] in_dst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTL_W-1:0]   out_ctl,
    output logic [DATA_W-1:0]  out_alu,
    output logic [DATA_W-1:0]  out_store,
    output logic [DATA_W-1:0]  out_target,
    output logic               out_zero,
    output logic [RADDR_W-1:0] out_dst,
    input  logic               flush,
    output logic               br_taken,
    output logic               fwd_en,
    output logic [RADDR_W-1:0] fwd_dst,
    output logic [DATA_W-1:0]  fwd_data
);

    localparam int PAY_W = $bits(stage_hdr_t) + 3 * DATA_W + RADDR_W;

    stage_hdr_t       in_hdr;
    stage_hdr_t       head_hdr;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] head_data;
    logic [PAY_W-1:0] skid_data;
    logic [PAY_W-1:0] head_d;
    logic             head_valid;
    logic             skid_valid;
    logic             head_valid_d;
    logic             skid_valid_d;
    logic             head_load;
    logic             skid_load;
    logic             push;
    logic             pop;
    logic             in_ready_q;

    assign in_hdr = '{ctl: in_ctl, zero: in_zero};
    assign in_pay = {in_hdr, in_alu, in_store, in_target, in_dst};

    assign push = in_valid & in_ready_q;
    assign pop  = head_valid & out_ready;

    // Skid feeds the head whenever it is occupied; push cannot coincide then.
    always_comb begin
        head_load    = 1'b0;
        skid_load    = 1'b0;
        head_d       = skid_valid ? skid_data : in_pay;
        head_valid_d = head_valid;
        skid_valid_d = skid_valid;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            head_load = (pop & skid_valid) | (push & (~head_valid | pop));
            skid_load = push & head_valid & ~pop;
            if (head_load) begin
                head_valid_d = 1'b1;
            end else if (pop) begin
                head_valid_d = 1'b0;
            end
            if (skid_load) begin
                skid_valid_d = 1'b1;
            end else if (pop) begin
                skid_valid_d = 1'b0;
            end
        end
    end

    pipe_entry_reg #(.W(PAY_W)) u_head (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_d (head_valid_d),
        .load    (head_load),
        .data_d  (head_d),
        .valid   (head_valid),
        .data    (head_data)
    );

    pipe_entry_reg #(.W(PAY_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_d (skid_valid_d),
        .load    (skid_load),
        .data_d  (in_pay),
        .valid   (skid_valid),
        .data    (skid_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= ~skid_valid_d;
        end
    end

    assign in_ready = in_ready_q;
    assign {head_hdr, out_alu, out_store, out_target, out_dst} = head_data;

    assign out_valid = head_valid;
    assign out_ctl   = head_valid ? head_hdr.ctl : '0;
    assign out_zero  = head_hdr.zero;

    assign br_taken  = head_valid & out_ctl[CTL_BRANCH] & out_zero;
    assign fwd_en    = head_valid & out_ctl[CTL_REGWR] & (out_dst != '0);
    assign fwd_dst   = out_dst;
    assign fwd_data  = out_alu;

endmodule
